cla_multiword_add_sequencer: RTL and testbench

//  Multi-cycle add/subtract engine for WIDTH-bit operands built on one shared 16-bit CLA slice.

---
 rtl/cla_seq_pkg.sv | 10 +
 rtl/sixteen_bit_carry_look_ahead_adder.sv | 47 ++++
 rtl/cla_multiword_add_sequencer.sv | 93 +++++++++
 tb/tb_cla_multiword_add_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the multi-word CLA add/subtract sequencer.
package cla_seq_pkg;
    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sixteen_bit_carry_look_ahead_adder.sv
// 16-bit two-level carry look-ahead adder: four 4-bit groups plus a group-level carry unit.
module sixteen_bit_carry_look_ahead_adder #(
    parameter int NUM_GRP = 4
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0]        g, p;
    logic [NUM_GRP-1:0] gg, gp;
    logic [NUM_GRP:0]   gc;

    assign g = a & b;
    assign p = a ^ b;

    // Group carries are formed only from group G/P and cin, never from each other.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    assign cout  = gc[4];

    for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
        logic [3:0] gl, pl, c;
        logic       cg;
        assign gl = g[gi*4 +: 4];
        assign pl = p[gi*4 +: 4];
        assign cg = gc[gi];

        assign gg[gi] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                      | (pl[3] & pl[2] & pl[1] & gl[0]);
        assign gp[gi] = &pl;

        assign c[0] = cg;
        assign c[1] = gl[0] | (pl[0] & cg);
        assign c[2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & cg);
        assign c[3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                    | (pl[2] & pl[1] & pl[0] & cg);

        assign sum[gi*4 +: 4] = pl ^ c;
    end
endmodule

// File: rtl/cla_multiword_add_sequencer.sv
// WIDTH-bit add/subtract engine that streams 16-bit slices LSB-first through one shared CLA.
module cla_multiword_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("cla_multiword_add_sequencer: WIDTH must be a multiple of 16 and >= 16");
    end

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              carry;
    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic              c_sl, acc, last;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;
    assign acc       = in_valid && in_ready;
    assign last      = (idx == LAST);

    assign a_sl = a_q[int'(idx)*SLICE_W +: SLICE_W];
    assign b_sl = b_q[int'(idx)*SLICE_W +: SLICE_W];

    sixteen_bit_carry_look_ahead_adder u_cla (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_sl)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc)       state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // b_q holds the already-inverted operand for subtract, so RUN only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (acc) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[int'(idx)*SLICE_W +: SLICE_W] <= s_sl;
            carry <= c_sl;
            if (last) begin
                cout <= c_sl;
                ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sl[SLICE_W-1] != a_q[WIDTH-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cla_multiword_add_sequencer.sv
// Directed plus random checks of the sequencer against a full-width arithmetic model.
module tb_cla_multiword_add_sequencer;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
    logic [63:0] a, b, sum;
    int          checks = 0;
    int          failures = 0;

    cla_multiword_add_sequencer #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain 65-bit arithmetic.
    function automatic logic [65:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic msub, input logic mcin);
        logic [63:0] be;
        logic [64:0] r;
        logic        v;
        be = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, be} + 65'(msub ? 1'b1 : mcin);
        v  = (ma[63] == be[63]) && (r[63] != ma[63]);
        return {v, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                         input logic tc);
        int n = 0;
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("accept_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
    endtask

    task automatic check_res(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                             input logic ts, input logic tc);
        logic [65:0] m;
        m = model(ta, tb, ts, tc);
        chk({tag, "_sum"},  sum,  m[63:0]);
        chk({tag, "_cout"}, cout, m[64]);
        chk({tag, "_ovf"},  ovf,  m[65]);
    endtask

    task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic ts, input logic tc);
        int n;
        start(ta, tb, ts, tc);
        wait_done(n);
        chk({tag, "_lat"}, n, 4);
        check_res(tag, ta, tb, ts, tc);
        chk({tag, "_inrdy_done"}, in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drained"}, out_valid, 1'b0);
        chk({tag, "_inrdy_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [63:0] ra, rb;
        logic [65:0] m1;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        #1;
        chk("rst_inrdy", in_ready, 1'b0);
        tick(); tick();
        chk("rst_outvalid", out_valid, 1'b0);
        chk("rst_sum", sum, 64'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_release_inrdy", in_ready, 1'b1);

        // Directed corner cases
        run_op("t1_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        chk("t1_sum_const", sum, 64'h0);
        run_op("t2_ripple", 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
        chk("t2_sum_const", sum, 64'h0000_0001_0000_0000);
        run_op("t3_sub_neg", 64'd5, 64'd7, 1'b1, 1'b0);
        chk("t3_sum_const", sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t3_cout_const", cout, 1'b0);
        run_op("t3_sub_pos", 64'd7, 64'd5, 1'b1, 1'b1);
        chk("t3b_sum_const", sum, 64'd2);
        run_op("t4_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        chk("t4_ovf_const", ovf, 1'b1);

        // Backpressure: hold DONE while a second request waits
        start(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1);
        wait_done(n);
        chk("t5_lat", n, 4);
        m1 = model(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1);
        a = 64'h8000_0000_0000_0000; b = 64'h0000_0000_0000_0001; sub = 1'b1; cin = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_sum", sum, m1[63:0]);
            chk("t5_hold_inrdy", in_ready, 1'b0);
            chk("t5_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_drain_inrdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_done(n);
        chk("t5_op2_lat", n, 4);
        check_res("t5_op2", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while the third slice is about to be computed
        start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_inrdy", in_ready, 1'b0);
        tick();
        chk("t6_outvalid", out_valid, 1'b0);
        chk("t6_sum", sum, 64'h0);
        chk("t6_cout", cout, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_inrdy", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("t6_no_result", seen, 1'b0);
        run_op("t6_recover", 64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0);

        // Random operands, biased toward long carry chains
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(3) == 0) rb = ~ra ^ 64'(($urandom_range(1) == 0) ? 0 : 1);
            if ($urandom_range(5) == 0) ra = {1'b0, {63{1'b1}}};
            run_op("rnd", ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
